// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 4-digit seven-segment scan driver: display constants,
// the active-low hex glyph table and the digit-scan state encoding.
package seg7_defs;

  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_state_e;

  // Index of the most significant non-zero nibble; 0 when the whole value is zero.
  function automatic logic [1:0] top_digit(input logic [15:0] v);
    logic [1:0] msd;
    msd = 2'd0;
    for (int k = 1; k < DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) msd = 2'(k);
    end
    return msd;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex7_decode.sv
// Combinational 4-bit to 7-segment decoder, active-low cathodes {g..a}.
module hex7_decode
  import seg7_defs::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexes a 16-bit hex value onto a 4-digit common-anode display with tear-free
// frame-boundary updates. Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_driver
  import seg7_defs::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  scan_state_e     state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     pending_q, pending_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            wrap_q;
  logic            frame_tick_q;

  logic            step;
  logic            wrap;
  logic [1:0]      idx;
  logic [3:0]      nibble;
  logic [6:0]      dec_seg;
  logic            lit;

  assign step = (presc_q == PRESC_LAST);
  assign wrap = step && (state_q == SCAN3);
  assign idx  = state_q;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SCAN0;
    else       state_q <= state_d;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (step) begin
      case (state_q)
        SCAN0:   state_d = SCAN1;
        SCAN1:   state_d = SCAN2;
        SCAN2:   state_d = SCAN3;
        SCAN3:   state_d = SCAN0;
        default: state_d = SCAN0;
      endcase
    end
  end

  assign nibble = shadow_q[{idx, 2'b00} +: 4];

  hex7_decode u_hex7_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    lit = (idx <= top_digit(shadow_q));
`else
    lit = 1'b1;
`endif
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!blank && lit) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = dec_seg;
    end
  end

  // A load coinciding with the frame wrap bypasses pending so it shows this frame.
  always_comb begin
    presc_d   = step ? '0 : presc_q + 1'b1;
    pending_d = load ? value : pending_q;
    shadow_d  = shadow_q;
    if (wrap) shadow_d = load ? value : pending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      wrap_q       <= wrap;
      frame_tick_q <= wrap_q;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
